fp_divider_arbiter: RTL

Round-robin arbiter that shares one pipelined `fp_divider` between `NUM_REQ` requesters, such as the matrix divider and the normalisation stage of the LCMV classifier. It does not instantiate the divider. It drives the divider's operand and issue ports, and it records which requester owns each in-flight operation in a tag delay line. Each quotient is returned only to the requester that issued it, in issue order.

---
 rtl/fp_divider_arbiter_if.sv | 34 +++
 rtl/fp_divider_arbiter.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/fp_divider_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : fp_divider_arbiter_if
// Description : Requester and divider-side bus of the shared fp_divider arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface fp_divider_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int WIDTH   = 32
);
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*WIDTH-1:0] req_a;
    logic [NUM_REQ*WIDTH-1:0] req_b;
    logic [NUM_REQ-1:0]       grant;
    logic [NUM_REQ-1:0]       resp_valid;
    logic [WIDTH-1:0]         resp_data;
    logic [WIDTH-1:0]         div_a;
    logic [WIDTH-1:0]         div_b;
    logic                     div_ready;
    logic [WIDTH-1:0]         div_o;
    logic                     div_valid;

    // master: requesters plus divider; slave: the arbiter
    modport master (
        output req, req_a, req_b, div_o, div_valid,
        input  grant, resp_valid, resp_data, div_a, div_b, div_ready
    );

    modport slave (
        input  req, req_a, req_b, div_o, div_valid,
        output grant, resp_valid, resp_data, div_a, div_b, div_ready
    );
endinterface
`default_nettype wire

// File: rtl/fp_divider_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fp_divider_arbiter
// Description : Round-robin sharing of one pipelined fp_divider between NUM_REQ
//               requesters; optional tag checker under FP_DIV_ARB_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_divider_arbiter #(
    parameter int NUM_REQ         = 2,
    parameter int WIDTH           = 32,
    parameter int DIVIDER_LATENCY = 28
) (
    input  logic                clk,
    input  logic                rst,
    fp_divider_arbiter_if.slave bus,
    output logic                busy,
    output logic                err
);
    localparam int IDX_WIDTH = $clog2(NUM_REQ);

    logic [IDX_WIDTH-1:0]       r_ptr;
    logic                       r_div_ready;
    logic [WIDTH-1:0]           r_div_a;
    logic [WIDTH-1:0]           r_div_b;
    logic [IDX_WIDTH-1:0]       r_issue_idx;
    logic [DIVIDER_LATENCY-1:0] r_tag_v;
    logic [IDX_WIDTH-1:0]       r_tag_idx [DIVIDER_LATENCY];

    logic                       w_found;
    logic [IDX_WIDTH-1:0]       w_win;
    int                         w_cand;
    logic [NUM_REQ-1:0]         w_grant;
    logic [IDX_WIDTH-1:0]       w_ptr_next;
    logic                       w_tag_v;
    logic [IDX_WIDTH-1:0]       w_tag_idx;
    logic [NUM_REQ-1:0]         w_resp_valid;

    // Scan upward from r_ptr with wrap; first asserted request wins.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_cand  = 0;
        for (int off = 0; off < NUM_REQ; off++) begin
            w_cand = int'(r_ptr) + off;
            if (w_cand >= NUM_REQ) begin
                w_cand = w_cand - NUM_REQ;
            end
            if (!w_found && bus.req[w_cand[IDX_WIDTH-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_cand[IDX_WIDTH-1:0];
            end
        end
        if (rst) begin
            w_found = 1'b0;
        end
        w_grant = '0;
        if (w_found) begin
            w_grant[w_win] = 1'b1;
        end
        w_ptr_next = (w_win == IDX_WIDTH'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr       <= '0;
            r_div_ready <= 1'b0;
            r_div_a     <= '0;
            r_div_b     <= '0;
            r_issue_idx <= '0;
        end else begin
            r_div_ready <= w_found;
            if (w_found) begin
                r_ptr       <= w_ptr_next;
                r_div_a     <= bus.req_a[w_win*WIDTH +: WIDTH];
                r_div_b     <= bus.req_b[w_win*WIDTH +: WIDTH];
                r_issue_idx <= w_win;
            end
        end
    end

    // Owner tag of every in-flight operation, aligned with div_valid at the tail.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tag_v <= '0;
            for (int i = 0; i < DIVIDER_LATENCY; i++) begin
                r_tag_idx[i] <= '0;
            end
        end else begin
            r_tag_v[0]   <= r_div_ready;
            r_tag_idx[0] <= r_issue_idx;
            for (int i = 1; i < DIVIDER_LATENCY; i++) begin
                r_tag_v[i]   <= r_tag_v[i-1];
                r_tag_idx[i] <= r_tag_idx[i-1];
            end
        end
    end

    assign w_tag_v   = r_tag_v[DIVIDER_LATENCY-1];
    assign w_tag_idx = r_tag_idx[DIVIDER_LATENCY-1];

    always_comb begin
        w_resp_valid = '0;
        if (bus.div_valid && w_tag_v) begin
            w_resp_valid[w_tag_idx] = 1'b1;
        end
    end

    assign bus.grant      = w_grant;
    assign bus.resp_valid = w_resp_valid;
    assign bus.resp_data  = bus.div_o;
    assign bus.div_a      = r_div_a;
    assign bus.div_b      = r_div_b;
    assign bus.div_ready  = r_div_ready;
    assign busy           = r_div_ready | (|r_tag_v);

`ifdef FP_DIV_ARB_CHECK_EN
    logic r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (bus.div_valid != w_tag_v) begin
            r_err <= 1'b1;
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!rst && (bus.div_valid != w_tag_v)) begin
            $error("fp_divider_arbiter: div_valid=%0b disagrees with tag valid=%0b",
                   bus.div_valid, w_tag_v);
        end
    end
`endif

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

endmodule
`default_nettype wire
